// File: rtl/fifo_wrr_scheduler_pkg.sv
// Shared encodings for the two-FIFO weighted scheduler: FSM states, grant
// source codes and the statistics counter width.
package fifo_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic SRC_HP = 1'b0;
   localparam logic SRC_LP = 1'b1;

   localparam int STAT_WIDTH = 16;

   function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/fifo_wrr_scheduler_if.sv
// Bundle of the two FIFO read ports and the downstream stream.
// master = scheduler side, slave = FIFOs plus consumer.
interface fifo_wrr_scheduler_if #(
   parameter int DATA_WIDTH = 16
);
   // out stream: a word transfers on a rising clk edge where out_valid && out_ready;
   // while out_valid=1 and out_ready=0, out_data/out_src are held unchanged.
   // FIFO side: a rd_en strobe in cycle N yields dout in cycle N+1.
   logic                  hp_empty;
   logic [DATA_WIDTH-1:0] hp_data;
   logic                  hp_rd_en;
   logic                  lp_empty;
   logic [DATA_WIDTH-1:0] lp_data;
   logic                  lp_rd_en;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_src;

   modport master (
      input  hp_empty, hp_data, lp_empty, lp_data, out_ready,
      output hp_rd_en, lp_rd_en, out_valid, out_data, out_src
   );

   modport slave (
      output hp_empty, hp_data, lp_empty, lp_data, out_ready,
      input  hp_rd_en, lp_rd_en, out_valid, out_data, out_src
   );

endinterface

// File: rtl/fifo_wrr_scheduler_arb.sv
// Grant rule plus HP streak counter; grants are only issued while grant_en_i
// marks a grant opportunity, and the streak only moves on a grant.
module fifo_sched_arb #(
   parameter int HP_WEIGHT = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic grant_en_i,
   input  logic strict_mode_i,
   input  logic hp_empty_i,
   input  logic lp_empty_i,
   output logic grant_hp_o,
   output logic grant_lp_o
);

   logic [CNT_WIDTH-1:0] streak_q, streak_d;
   logic                 lp_force;

   always_comb begin
      lp_force   = !lp_empty_i && !hp_empty_i && !strict_mode_i &&
                   (streak_q >= CNT_WIDTH'(HP_WEIGHT));
      grant_hp_o = grant_en_i && !hp_empty_i && !lp_force;
      grant_lp_o = grant_en_i && !lp_empty_i && (lp_force || hp_empty_i);
      streak_d   = streak_q;
      // The streak only measures HP wins while LP is actually waiting.
      if (grant_lp_o) begin
         streak_d = '0;
      end else if (grant_hp_o) begin
         if (lp_empty_i) begin
            streak_d = '0;
         end else if (streak_q != '1) begin
            streak_d = streak_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

endmodule

// File: rtl/fifo_wrr_scheduler.sv
// Two-FIFO read scheduler: IDLE/FETCH/HOLD FSM, output data register and
// optional grant statistics (enabled by defining SCHED_STATS_EN).
module fifo_wrr_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int HP_WEIGHT  = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   strict_mode,
   fifo_wrr_scheduler_if.master   bus,
   output state_t                 dbg_state_o
`ifdef SCHED_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0]  hp_grant_cnt,
   output logic [STAT_WIDTH-1:0]  lp_grant_cnt
`endif
);

   state_t                state_q, state_d;
   logic                  grant_en, grant_hp, grant_lp;
   logic                  src_q, src_d;
   logic                  out_src_q;
   logic [DATA_WIDTH-1:0] data_q;

   assign grant_en = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);

   fifo_sched_arb #(
      .HP_WEIGHT (HP_WEIGHT),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_arb (
      .clk           (clk),
      .rst           (rst),
      .grant_en_i    (grant_en),
      .strict_mode_i (strict_mode),
      .hp_empty_i    (bus.hp_empty),
      .lp_empty_i    (bus.lp_empty),
      .grant_hp_o    (grant_hp),
      .grant_lp_o    (grant_lp)
   );

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      case (state_q)
         IDLE:    state_d = (grant_hp || grant_lp) ? FETCH : IDLE;
         FETCH:   state_d = HOLD;
         HOLD:    if (bus.out_ready) state_d = (grant_hp || grant_lp) ? FETCH : IDLE;
         default: state_d = IDLE;
      endcase
      if (grant_lp) begin
         src_d = SRC_LP;
      end else if (grant_hp) begin
         src_d = SRC_HP;
      end
   end

   // src_q remembers which FIFO was read so FETCH captures the matching dout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         src_q     <= SRC_HP;
         out_src_q <= SRC_HP;
         data_q    <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         if (state_q == FETCH) begin
            data_q    <= (src_q == SRC_LP) ? bus.lp_data : bus.hp_data;
            out_src_q <= src_q;
         end
      end
   end

   assign bus.hp_rd_en  = grant_hp;
   assign bus.lp_rd_en  = grant_lp;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_data  = data_q;
   assign bus.out_src   = out_src_q;
   assign dbg_state_o   = state_q;

`ifdef SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hp_grant_cnt <= '0;
         lp_grant_cnt <= '0;
      end else begin
         if (grant_hp) hp_grant_cnt <= stat_inc(hp_grant_cnt);
         if (grant_lp) lp_grant_cnt <= stat_inc(lp_grant_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wrr_scheduler.sv
// Directed bench for fifo_wrr_scheduler with behavioural FIFOs (1-cycle dout)
// on both read ports; inputs change and outputs are sampled on the falling edge.
module tb_fifo_wrr_scheduler;
   import fifo_sched_pkg::*;

   logic   clk = 1'b0;
   logic   rst;
   logic   strict_mode;
   state_t dbg_state;
`ifdef SCHED_STATS_EN
   logic [15:0] hp_cnt, lp_cnt;
`endif

   int tests_run    = 0;
   int tests_failed = 0;
   int viol_cnt     = 0;

   logic [15:0] hp_mem [0:127];
   logic [15:0] lp_mem [0:127];
   logic [6:0]  hp_wr = 7'd0, hp_rd = 7'd0, lp_wr = 7'd0, lp_rd = 7'd0;
   logic [16:0] out_log [$];
   logic        grant_log [$];

   fifo_wrr_scheduler_if #(.DATA_WIDTH(16)) bus ();

   fifo_wrr_scheduler #(
      .DATA_WIDTH (16),
      .HP_WEIGHT  (4),
      .CNT_WIDTH  (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .strict_mode  (strict_mode),
      .bus          (bus),
      .dbg_state_o  (dbg_state)
`ifdef SCHED_STATS_EN
      ,
      .hp_grant_cnt (hp_cnt),
      .lp_grant_cnt (lp_cnt)
`endif
   );

   // ---------------- clock / FIFO models / monitor ----------------
   always #5 clk = ~clk;

   assign bus.hp_empty = (hp_wr == hp_rd);
   assign bus.lp_empty = (lp_wr == lp_rd);

   always @(posedge clk) begin
      if (bus.hp_rd_en) begin
         bus.hp_data <= hp_mem[hp_rd];
         hp_rd       <= hp_rd + 7'd1;
      end
      if (bus.lp_rd_en) begin
         bus.lp_data <= lp_mem[lp_rd];
         lp_rd       <= lp_rd + 7'd1;
      end
      if (!rst) begin
         if (bus.hp_rd_en) grant_log.push_back(1'b0);
         if (bus.lp_rd_en) grant_log.push_back(1'b1);
         if (bus.out_valid && bus.out_ready) out_log.push_back({bus.out_src, bus.out_data});
         if ((bus.hp_rd_en && bus.lp_rd_en) || (bus.hp_rd_en && bus.hp_empty) ||
             (bus.lp_rd_en && bus.lp_empty))
            viol_cnt <= viol_cnt + 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish by 100000 time units");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic push_hp(input logic [15:0] d);
      hp_mem[hp_wr] = d;
      hp_wr = hp_wr + 7'd1;
   endtask

   task automatic push_lp(input logic [15:0] d);
      lp_mem[lp_wr] = d;
      lp_wr = lp_wr + 7'd1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      strict_mode = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         tests_run++;
         if ((bus.hp_rd_en !== 1'b0) || (bus.lp_rd_en !== 1'b0)) begin
            tests_failed++;
            $display("FAIL reset_rd_en cyc %0d: hp=%b lp=%b expected 0 0", c, bus.hp_rd_en, bus.lp_rd_en);
         end
         tests_run++;
         if ((bus.out_valid !== 1'b0) || (bus.out_data !== 16'h0) || (dbg_state !== IDLE)) begin
            tests_failed++;
            $display("FAIL reset_out cyc %0d: valid=%b data=%h state=%0d expected 0 0000 0",
                     c, bus.out_valid, bus.out_data, dbg_state);
         end
      end
`ifdef SCHED_STATS_EN
      tests_run++;
      if ((hp_cnt !== 16'd0) || (lp_cnt !== 16'd0)) begin
         tests_failed++;
         $display("FAIL reset_stats: hp=%0d lp=%0d expected 0 0", hp_cnt, lp_cnt);
      end
`endif
   endtask

   task automatic test_single_hp();
      bus.out_ready = 1'b1;
      push_hp(16'hA5A5);
      #1;
      tests_run++;
      if ((bus.hp_rd_en !== 1'b1) || (bus.lp_rd_en !== 1'b0)) begin
         tests_failed++;
         $display("FAIL single_hp_grant: hp=%b lp=%b expected 1 0", bus.hp_rd_en, bus.lp_rd_en);
      end
      @(negedge clk);
      tests_run++;
      if ((bus.out_valid !== 1'b0) || (bus.hp_rd_en !== 1'b0) || (dbg_state !== FETCH)) begin
         tests_failed++;
         $display("FAIL single_hp_fetch: valid=%b rd=%b state=%0d expected 0 0 1",
                  bus.out_valid, bus.hp_rd_en, dbg_state);
      end
      @(negedge clk);
      tests_run++;
      if ((bus.out_valid !== 1'b1) || (bus.out_data !== 16'hA5A5) || (bus.out_src !== 1'b0)) begin
         tests_failed++;
         $display("FAIL single_hp_out: valid=%b data=%h src=%b expected 1 a5a5 0",
                  bus.out_valid, bus.out_data, bus.out_src);
      end
      @(negedge clk);
      tests_run++;
      if ((bus.out_valid !== 1'b0) || (dbg_state !== IDLE)) begin
         tests_failed++;
         $display("FAIL single_hp_idle: valid=%b state=%0d expected 0 0", bus.out_valid, dbg_state);
      end
   endtask

   task automatic test_single_lp();
      push_lp(16'h5A5A);
      #1;
      tests_run++;
      if ((bus.lp_rd_en !== 1'b1) || (bus.hp_rd_en !== 1'b0)) begin
         tests_failed++;
         $display("FAIL single_lp_grant: lp=%b hp=%b expected 1 0", bus.lp_rd_en, bus.hp_rd_en);
      end
      repeat (2) @(negedge clk);
      tests_run++;
      if ((bus.out_valid !== 1'b1) || (bus.out_data !== 16'h5A5A) || (bus.out_src !== 1'b1)) begin
         tests_failed++;
         $display("FAIL single_lp_out: valid=%b data=%h src=%b expected 1 5a5a 1",
                  bus.out_valid, bus.out_data, bus.out_src);
      end
      @(negedge clk);
   endtask

   // Preload 8 HP + 2 LP, drain with out_ready=1, compare grant and word order.
   task automatic test_drain(input logic strict, input string name);
      logic [16:0] exp_q [$];
      int cyc;
      strict_mode = strict;
      bus.out_ready = 1'b1;
      out_log.delete();
      grant_log.delete();
      for (int i = 0; i < 8; i++) push_hp(16'(16'h1000 + i));
      for (int i = 0; i < 2; i++) push_lp(16'(16'h2000 + i));
      if (strict) begin
         for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 16'(16'h1000 + i)});
         for (int i = 0; i < 2; i++) exp_q.push_back({1'b1, 16'(16'h2000 + i)});
      end else begin
         for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 16'(16'h1000 + i)});
         exp_q.push_back({1'b1, 16'h2000});
         for (int i = 4; i < 8; i++) exp_q.push_back({1'b0, 16'(16'h1000 + i)});
         exp_q.push_back({1'b1, 16'h2001});
      end
      cyc = 0;
      while ((out_log.size() < 10) && (cyc < 200)) begin
         @(negedge clk);
         cyc++;
      end
      repeat (2) @(negedge clk);
      tests_run++;
      if ((out_log.size() != 10) || (grant_log.size() != 10)) begin
         tests_failed++;
         $display("FAIL %s_count: words=%0d grants=%0d expected 10 10", name, out_log.size(), grant_log.size());
      end
      for (int i = 0; i < 10; i++) begin
         tests_run++;
         if ((i >= out_log.size()) || (i >= grant_log.size()) ||
             (out_log[i] !== exp_q[i]) || (grant_log[i] !== exp_q[i][16])) begin
            tests_failed++;
            $display("FAIL %s_word%0d: got src/data %h grant %b expected %h", name, i,
                     (i < out_log.size()) ? out_log[i] : 17'h0,
                     (i < grant_log.size()) ? grant_log[i] : 1'bx, exp_q[i]);
         end
      end
      strict_mode = 1'b0;
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      push_hp(16'hB001);
      push_hp(16'hB002);
      repeat (2) @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         tests_run++;
         if ((bus.out_valid !== 1'b1) || (bus.out_data !== 16'hB001) ||
             (bus.hp_rd_en !== 1'b0) || (bus.lp_rd_en !== 1'b0)) begin
            tests_failed++;
            $display("FAIL backpressure_hold cyc %0d: valid=%b data=%h rd=%b%b expected 1 b001 00",
                     c, bus.out_valid, bus.out_data, bus.hp_rd_en, bus.lp_rd_en);
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      #1;
      tests_run++;
      if (bus.hp_rd_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL backpressure_regrant: hp_rd_en=%b expected 1", bus.hp_rd_en);
      end
      repeat (2) @(negedge clk);
      tests_run++;
      if ((bus.out_valid !== 1'b1) || (bus.out_data !== 16'hB002) || (bus.out_src !== 1'b0)) begin
         tests_failed++;
         $display("FAIL backpressure_second: valid=%b data=%h src=%b expected 1 b002 0",
                  bus.out_valid, bus.out_data, bus.out_src);
      end
      @(negedge clk);
   endtask

`ifdef SCHED_STATS_EN
   task automatic test_stats();
      // 1 + 8 + 8 + 2 HP grants and 1 + 2 + 2 LP grants so far
      tests_run++;
      if ((hp_cnt !== 16'd19) || (lp_cnt !== 16'd5)) begin
         tests_failed++;
         $display("FAIL stats_counts: hp=%0d lp=%0d expected 19 5", hp_cnt, lp_cnt);
      end
   endtask
`endif

   task automatic test_reset_mid_fetch();
      bus.out_ready = 1'b1;
      push_hp(16'hC0DE);
      @(negedge clk);
      tests_run++;
      if (dbg_state !== FETCH) begin
         tests_failed++;
         $display("FAIL midrst_pre: state=%0d expected 1", dbg_state);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if ((bus.out_valid !== 1'b0) || (dbg_state !== IDLE) || (bus.hp_rd_en !== 1'b0)) begin
         tests_failed++;
         $display("FAIL midrst_now: valid=%b state=%0d rd=%b expected 0 0 0",
                  bus.out_valid, dbg_state, bus.hp_rd_en);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ((bus.out_valid !== 1'b0) || (bus.out_data !== 16'h0) || (dbg_state !== IDLE)) begin
         tests_failed++;
         $display("FAIL midrst_after: valid=%b data=%h state=%0d expected 0 0000 0",
                  bus.out_valid, bus.out_data, dbg_state);
      end
`ifdef SCHED_STATS_EN
      tests_run++;
      if ((hp_cnt !== 16'd0) || (lp_cnt !== 16'd0)) begin
         tests_failed++;
         $display("FAIL midrst_stats: hp=%0d lp=%0d expected 0 0", hp_cnt, lp_cnt);
      end
`endif
   endtask

   task automatic test_protocol();
      tests_run++;
      if (viol_cnt != 0) begin
         tests_failed++;
         $display("FAIL strobe_protocol: violations=%0d expected 0", viol_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_hp();
      test_single_lp();
      test_drain(1'b0, "anti_starvation");
      test_drain(1'b1, "strict");
      test_backpressure();
`ifdef SCHED_STATS_EN
      test_stats();
`endif
      test_reset_mid_fetch();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
